// File: rtl/ex_forward_ctrl.sv
// EX-stage forwarding select and load-use stall control.
// Shadows the destination/write-enable of the EX, MEM and WB instructions
// and steers the two EX operand muxes toward the youngest producer.
module ex_forward_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic [REG_W-1:0] id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             flush_i,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  logic [REG_W-1:0] ex_rs, ex_rt, ex_rd;
  logic             ex_rw, ex_mr;
  logic [REG_W-1:0] mem_rd, wb_rd;
  logic             mem_rw, wb_rw;
  logic [CNT_W-1:0] stall_cnt;
  logic             bubble;
  fwd_sel_e         sel_a, sel_b;

  // MEM holds the younger value, so it is checked before WB; r0 is never a source.
  function automatic fwd_sel_e pick_src(input logic [REG_W-1:0] src);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (mem_rw && (mem_rd != '0) && (mem_rd == src))
      sel = FWD_MEM;
    else if (wb_rw && (wb_rd != '0) && (wb_rd == src))
      sel = FWD_WB;
    return sel;
  endfunction

  // Operand selects depend only on registered pipeline state.
  always_comb begin
    sel_a = pick_src(ex_rs);
    sel_b = pick_src(ex_rt);
  end

  assign fwd_a_o = sel_a;
  assign fwd_b_o = sel_b;

  // Load in EX whose result the ID instruction needs; a flush squashes the ID side.
  always_comb begin
    stall_o = ex_mr && (ex_rd != '0) &&
              ((ex_rd == id_rs_i) || (ex_rd == id_rt_i)) && !flush_i;
    bubble  = flush_i || stall_o;
  end

  // Advance the shadow pipeline; EX receives a bubble on flush or stall.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_rs  <= '0;
      ex_rt  <= '0;
      ex_rd  <= '0;
      ex_rw  <= 1'b0;
      ex_mr  <= 1'b0;
      mem_rd <= '0;
      mem_rw <= 1'b0;
      wb_rd  <= '0;
      wb_rw  <= 1'b0;
    end else begin
      wb_rd  <= mem_rd;
      wb_rw  <= mem_rw;
      mem_rd <= ex_rd;
      mem_rw <= ex_rw;
      if (bubble) begin
        ex_rs <= '0;
        ex_rt <= '0;
        ex_rd <= '0;
        ex_rw <= 1'b0;
        ex_mr <= 1'b0;
      end else begin
        ex_rs <= id_rs_i;
        ex_rt <= id_rt_i;
        ex_rd <= id_rd_i;
        ex_rw <= id_regwrite_i;
        ex_mr <= id_memread_i;
      end
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      stall_cnt <= '0;
    else if (stall_o && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign stall_cnt_o = stall_cnt;

endmodule
